// File: rtl/usb_fifo_bridge.sv
// Cypress FX2 slave-FIFO bridge: parses command frames arriving on EP2 and streams an
// upstream FIFO out through EP6, committing short IN packets after an idle timeout.
module usb_fifo_bridge #(
  parameter int         DW        = 16,
  parameter int         CMD_WORDS = 8,
  parameter int         PKT_WORDS = 256,
  parameter int         IDLE_TO   = 1024,
  parameter logic [7:0] CMD_HEAD  = 8'h53,
  parameter logic [7:0] CMD_TAIL  = 8'hCD
) (
  input  logic                          usb_clk,
  input  logic                          sys_rst,
  input  logic                          fx2_flaga,
  input  logic                          fx2_flagc,
  output logic                          fx2_slcs_n,
  output logic                          fx2_slwr_n,
  output logic                          fx2_slrd_n,
  output logic                          fx2_sloe_n,
  output logic                          fx2_pktend_n,
  output logic [1:0]                    fx2_a,
  inout  wire  [DW-1:0]                 fx2_db,
  input  logic [DW-1:0]                 fifo_data,
  input  logic                          fifo_empty,
  output logic                          fifo_rd_req,
  output logic                          cmd_valid,
  output logic                          cmd_err,
  output logic [7:0]                    cmd_code,
  output logic [(CMD_WORDS-2)*DW-1:0]   cmd_arg,
  output logic                          led_usb
);

  localparam int IW  = (CMD_WORDS > 1) ? $clog2(CMD_WORDS) : 1;
  localparam int WCW = $clog2(PKT_WORDS + 1);
  localparam int ICW = $clog2(IDLE_TO + 1);
  localparam int AW  = (CMD_WORDS - 2) * DW;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD       = 3'd1;
  localparam logic [2:0] S_W_FETCH  = 3'd2;
  localparam logic [2:0] S_W_LATCH  = 3'd3;
  localparam logic [2:0] S_W_STROBE = 3'd4;
  localparam logic [2:0] S_PEND     = 3'd5;

  logic [2:0]     r_state;
  logic [2:0]     w_state_nxt;
  logic           r_phase;
  logic [WCW-1:0] r_wcnt;
  logic [ICW-1:0] r_icnt;
  logic [DW-1:0]  r_wdata;
  logic [IW-1:0]  r_idx;
  logic [7:0]     r_code_pend;
  logic [AW-1:0]  r_arg_pend;
  logic [7:0]     r_cmd_code;
  logic [AW-1:0]  r_cmd_arg;
  logic           r_cmd_valid;
  logic           r_cmd_err;

  logic           w_rx;
  logic [15:0]    w_rx16;
  logic           w_wr_ok;
  logic           w_timeout;
  logic           w_db_oe;

  assign w_rx      = (r_state == S_RD) && r_phase;
  assign w_rx16    = 16'(fx2_db);
  assign w_wr_ok   = fx2_flagc && !fifo_empty;
  assign w_timeout = (r_icnt == ICW'(IDLE_TO)) && (r_wcnt != '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (fx2_flaga)      w_state_nxt = S_RD;
        else if (w_wr_ok)   w_state_nxt = S_W_FETCH;
        else if (w_timeout) w_state_nxt = S_PEND;
      end
      // Leave only after a completed strobe so no word is ever half-read.
      S_RD:       if (r_phase && !fx2_flaga) w_state_nxt = S_IDLE;
      S_W_FETCH:  w_state_nxt = S_W_LATCH;
      S_W_LATCH:  w_state_nxt = S_W_STROBE;
      S_W_STROBE: begin
        if (fx2_flaga)    w_state_nxt = S_IDLE;
        else if (w_wr_ok) w_state_nxt = S_W_FETCH;
        else              w_state_nxt = S_IDLE;
      end
      S_PEND:     w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge usb_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state <= S_IDLE;
      r_phase <= 1'b0;
      r_wcnt  <= '0;
      r_icnt  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= (r_state == S_RD) ? ~r_phase : 1'b0;
      if (r_state == S_W_LATCH) r_wdata <= fifo_data;

      // A full packet is auto-committed by the FX2, so the count simply wraps.
      if (r_state == S_W_STROBE) begin
        if (r_wcnt == WCW'(PKT_WORDS - 1)) r_wcnt <= '0;
        else                               r_wcnt <= r_wcnt + WCW'(1);
      end else if (r_state == S_PEND) begin
        r_wcnt <= '0;
      end

      if (r_state == S_IDLE && r_wcnt != '0 && fifo_empty) begin
        if (r_icnt != ICW'(IDLE_TO)) r_icnt <= r_icnt + ICW'(1);
      end else begin
        r_icnt <= '0;
      end
    end
  end

  always_ff @(posedge usb_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_idx       <= '0;
      r_code_pend <= '0;
      r_arg_pend  <= '0;
      r_cmd_code  <= '0;
      r_cmd_arg   <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_err   <= 1'b0;
    end else begin
      r_cmd_valid <= 1'b0;
      r_cmd_err   <= 1'b0;
      if (w_rx) begin
        if (r_idx == '0) begin
          if (w_rx16[7:0] == CMD_HEAD) begin
            if (DW != 8) r_code_pend <= w_rx16[15:8];
            r_idx <= IW'(1);
          end else begin
            r_cmd_err <= 1'b1;
          end
        end else if (r_idx == IW'(CMD_WORDS - 1)) begin
          if (w_rx16[7:0] == CMD_TAIL) begin
            r_cmd_code  <= r_code_pend;
            r_cmd_arg   <= r_arg_pend;
            r_cmd_valid <= 1'b1;
          end else begin
            r_cmd_err <= 1'b1;
          end
          r_idx <= '0;
        end else begin
          if (DW == 8 && r_idx == IW'(1)) r_code_pend <= w_rx16[7:0];
          for (int k = 0; k < CMD_WORDS - 2; k++) begin
            if (r_idx == IW'(k + 1)) r_arg_pend[k*DW +: DW] <= w_rx16[DW-1:0];
          end
          r_idx <= r_idx + IW'(1);
        end
      end
    end
  end

  always_comb begin
    fx2_slcs_n   = 1'b1;
    fx2_slwr_n   = 1'b1;
    fx2_slrd_n   = 1'b1;
    fx2_sloe_n   = 1'b1;
    fx2_pktend_n = 1'b1;
    fx2_a        = 2'b00;
    fifo_rd_req  = 1'b0;
    w_db_oe      = 1'b0;
    case (r_state)
      S_RD: begin
        fx2_slcs_n = 1'b0;
        fx2_sloe_n = 1'b0;
        fx2_slrd_n = ~r_phase;
      end
      S_W_FETCH: fifo_rd_req = 1'b1;
      S_W_LATCH: begin
        fx2_slcs_n = 1'b0;
        fx2_a      = 2'b10;
        w_db_oe    = 1'b1;
      end
      S_W_STROBE: begin
        fx2_slcs_n = 1'b0;
        fx2_a      = 2'b10;
        fx2_slwr_n = 1'b0;
        w_db_oe    = 1'b1;
      end
      S_PEND: begin
        fx2_slcs_n   = 1'b0;
        fx2_a        = 2'b10;
        fx2_pktend_n = 1'b0;
      end
      default: ;
    endcase
  end

  assign fx2_db    = w_db_oe ? r_wdata : {DW{1'bz}};
  assign cmd_valid = r_cmd_valid;
  assign cmd_err   = r_cmd_err;
  assign cmd_code  = r_cmd_code;
  assign cmd_arg   = r_cmd_arg;
  assign led_usb   = (r_state == S_IDLE);

endmodule
